// File: rtl/axis_header_insert_sched_pkg.sv
// Shared types and default widths for the header-insert frame scheduler.
package axis_hdr_sched_pkg;

    localparam int unsigned P_DATA_WD      = 32;
    localparam int unsigned P_DATA_BYTE_WD = P_DATA_WD / 8;
    localparam int unsigned P_BYTE_CNT_WD  = $clog2(P_DATA_BYTE_WD);
    localparam int unsigned P_NUM_SRC      = 4;
    localparam int unsigned P_SRC_WD       = $clog2(P_NUM_SRC);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    typedef logic [P_SRC_WD-1:0] src_idx_t;

endpackage

// File: rtl/axis_header_insert_sched_if.sv
// Bundle of N header+payload stream pairs (flattened, lane i at [i*W +: W]).
// master drives valid/data side, slave drives the ready side.
interface axis_header_insert_sched_if #(
    parameter int unsigned N       = 1,
    parameter int unsigned DATA_WD = axis_hdr_sched_pkg::P_DATA_WD
);
    localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
    localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

    logic [N-1:0]              valid_in;
    logic [N*DATA_WD-1:0]      data_in;
    logic [N*DATA_BYTE_WD-1:0] keep_in;
    logic [N-1:0]              last_in;
    logic [N-1:0]              ready_in;

    logic [N-1:0]              valid_insert;
    logic [N*DATA_WD-1:0]      data_insert;
    logic [N*DATA_BYTE_WD-1:0] keep_insert;
    logic [N*BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic [N-1:0]              ready_insert;

    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_in, ready_insert
    );

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_in, ready_insert
    );

endinterface

// File: rtl/axis_header_insert_sched_rr_pick.sv
// Combinational rotating-priority picker: first set req scanning from ptr+1 with wrap.
module axis_rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_WD  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_WD-1:0]  ptr,
    output logic [SRC_WD-1:0]  gnt_idx,
    output logic               gnt_vld
);

    logic [SRC_WD-1:0] w_idx;

    // Scan candidates in rotated order, keep the first requester found.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_idx = SRC_WD'((32'(ptr) + k) % NUM_SRC);
            if (!gnt_vld && req[w_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/axis_header_insert_sched.sv
// Round-robin frame scheduler feeding a header inserter: one source owns both
// inserter ports from grant until its payload last beat is accepted.
module axis_header_insert_sched
    import axis_hdr_sched_pkg::*;
#(
    parameter int unsigned DATA_WD      = P_DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned NUM_SRC      = P_NUM_SRC,
    parameter int unsigned SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_header_insert_sched_if.slave  s,
    axis_header_insert_sched_if.master m,
    output logic [SRC_WD-1:0]          grant_id,
    output logic                       busy
);

    state_t              r_state;
    logic [SRC_WD-1:0]   r_ptr;
    logic                r_hdr_sent;

    logic [SRC_WD-1:0]   w_gnt_idx;
    logic                w_gnt_vld;
    logic                w_active;
    logic                w_hdr_open;
    logic                w_pl_gate;
    logic                w_hdr_hs;
    logic                w_last_hs;

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_WD  (SRC_WD)
    ) u_pick (
        .req     (s.valid_insert),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    // Route the granted pair to the inserter; the last payload beat is held back
    // until the header has been taken so the inserter never sees a headerless frame.
    always_comb begin
        w_active   = (r_state == FRAME) && !rst;
        w_hdr_open = w_active && !r_hdr_sent;
        w_pl_gate  = w_active && (!s.last_in[grant_id] || r_hdr_sent);

        m.valid_insert    = w_hdr_open && s.valid_insert[grant_id];
        m.data_insert     = s.data_insert[grant_id*DATA_WD +: DATA_WD];
        m.keep_insert     = s.keep_insert[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
        m.byte_insert_cnt = s.byte_insert_cnt[grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];

        m.valid_in = w_pl_gate && s.valid_in[grant_id];
        m.data_in  = s.data_in[grant_id*DATA_WD +: DATA_WD];
        m.keep_in  = s.keep_in[grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
        m.last_in  = s.last_in[grant_id];

        s.ready_insert           = '0;
        s.ready_in               = '0;
        s.ready_insert[grant_id] = w_hdr_open && m.ready_insert;
        s.ready_in[grant_id]     = w_pl_gate && m.ready_in;

        w_hdr_hs  = m.valid_insert && m.ready_insert;
        w_last_hs = m.valid_in && m.ready_in && m.last_in;
    end

    // Frame FSM: grant in IDLE, track header acceptance, release on last payload beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= SRC_WD'(NUM_SRC - 1);
            r_hdr_sent <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        grant_id   <= w_gnt_idx;
                        r_ptr      <= w_gnt_idx;
                        r_hdr_sent <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= FRAME;
                    end
                end
                FRAME: begin
                    if (w_hdr_hs) begin
                        r_hdr_sent <= 1'b1;
                    end
                    if (w_last_hs) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_header_insert_sched.sv
// Bench for axis_header_insert_sched: queue-driven sources, a frame-level
// reference model checked every cycle, and directed literal expectations.
module tb_axis_header_insert_sched;
    import axis_hdr_sched_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic [1:0]  c;
    } hdr_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } pay_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    src_idx_t grant_id;
    logic     busy;

    always #5 clk = ~clk;

    axis_header_insert_sched_if #(.N(NS), .DATA_WD(DW)) s_bus ();
    axis_header_insert_sched_if #(.N(1),  .DATA_WD(DW)) m_bus ();

    axis_header_insert_sched #(
        .DATA_WD      (DW),
        .DATA_BYTE_WD (KW),
        .BYTE_CNT_WD  (CW),
        .NUM_SRC      (NS),
        .SRC_WD       (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (s_bus),
        .m        (m_bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-source drivers: present queue heads, pop on observed handshake, flush on reset.
    for (genvar gi = 0; gi < NS; gi++) begin : g_src
        hdr_t hq[$];
        pay_t pq[$];
        bit   hv = 1'b0;
        bit   pv = 1'b0;
        hdr_t hcur = '0;
        pay_t pcur = '0;
        bit   h_hs, p_hs, fl;

        assign s_bus.valid_insert[gi]             = hv;
        assign s_bus.data_insert[gi*DW +: DW]     = hcur.d;
        assign s_bus.keep_insert[gi*KW +: KW]     = hcur.k;
        assign s_bus.byte_insert_cnt[gi*CW +: CW] = hcur.c;
        assign s_bus.valid_in[gi]                 = pv;
        assign s_bus.data_in[gi*DW +: DW]         = pcur.d;
        assign s_bus.keep_in[gi*KW +: KW]         = pcur.k;
        assign s_bus.last_in[gi]                  = pcur.l;

        always begin
            @(negedge clk);
            h_hs = hv && (s_bus.ready_insert[gi] === 1'b1);
            p_hs = pv && (s_bus.ready_in[gi] === 1'b1);
            fl   = rst;
            @(posedge clk);
            #1;
            if (fl) begin
                hq.delete();
                pq.delete();
            end else begin
                if (h_hs && hq.size() > 0) void'(hq.pop_front());
                if (p_hs && pq.size() > 0) void'(pq.pop_front());
            end
            hv   = hq.size() > 0;
            hcur = hv ? hq[0] : '0;
            pv   = pq.size() > 0;
            pcur = pv ? pq[0] : '0;
        end
    end

    // Reference model state (frame-level view)
    bit md_busy = 1'b0;
    int md_gid  = 0;
    bit md_hdr  = 1'b0;
    int md_ptr  = NS - 1;

    // DUT observation logs for directed checks
    int          glog[$];
    int          gcyc[$];
    int          hcyc[$];
    hdr_t        hlog[$];
    logic [31:0] plog[$];
    int          lcyc[$];
    int          busy_cnt, leak_cnt, early_vin, leak3;
    bit          prev_busy = 1'b0;

    // Compare process: model expectations vs DUT each cycle, then model advance and logging.
    always @(negedge clk) begin
        int         g;
        bit         act, gate, e_vins, e_vin, found;
        logic [3:0] e_rins, e_rin, other;
        g      = md_gid;
        act    = md_busy && !rst;
        gate   = !s_bus.last_in[g] || md_hdr;
        e_vins = act && s_bus.valid_insert[g] && !md_hdr;
        e_vin  = act && s_bus.valid_in[g] && gate;
        e_rins = (act && !md_hdr && m_bus.ready_insert) ? (4'b0001 << g) : 4'b0000;
        e_rin  = (act && gate && m_bus.ready_in) ? (4'b0001 << g) : 4'b0000;

        if (chk_en) begin
            chk("busy", busy, md_busy);
            if (md_busy) chk("grant_id", grant_id, g);
            chk("m_valid_insert", m_bus.valid_insert, e_vins);
            chk("m_valid_in", m_bus.valid_in, e_vin);
            chk("s_ready_insert", s_bus.ready_insert, e_rins);
            chk("s_ready_in", s_bus.ready_in, e_rin);
            if (e_vins) begin
                chk("m_data_insert", m_bus.data_insert, s_bus.data_insert[g*DW +: DW]);
                chk("m_keep_insert", m_bus.keep_insert, s_bus.keep_insert[g*KW +: KW]);
                chk("m_byte_insert_cnt", m_bus.byte_insert_cnt, s_bus.byte_insert_cnt[g*CW +: CW]);
            end
            if (e_vin) begin
                chk("m_data_in", m_bus.data_in, s_bus.data_in[g*DW +: DW]);
                chk("m_keep_in", m_bus.keep_in, s_bus.keep_in[g*KW +: KW]);
                chk("m_last_in", m_bus.last_in, s_bus.last_in[g]);
            end
        end

        if (busy && !prev_busy) begin
            glog.push_back(int'(grant_id));
            gcyc.push_back(cyc);
        end
        if (busy) busy_cnt++;
        if (m_bus.valid_insert && m_bus.ready_insert) begin
            hcyc.push_back(cyc);
            hlog.push_back({m_bus.data_insert, m_bus.keep_insert, m_bus.byte_insert_cnt});
        end
        if (m_bus.valid_in && hcyc.size() == 0) early_vin++;
        if (m_bus.valid_in && m_bus.ready_in) begin
            plog.push_back(m_bus.data_in);
            if (m_bus.last_in) lcyc.push_back(cyc);
        end
        other = (s_bus.ready_in | s_bus.ready_insert) & ~(busy ? (4'b0001 << grant_id) : 4'b0000);
        if (other != 4'b0000) leak_cnt++;
        if (m_bus.valid_insert && m_bus.data_insert == 32'h6300_0033 && (!busy || grant_id != 2'd3)) leak3++;
        prev_busy = busy;

        if (rst) begin
            md_busy = 1'b0;
            md_gid  = 0;
            md_hdr  = 1'b0;
            md_ptr  = NS - 1;
        end else if (!md_busy) begin
            found = 1'b0;
            for (int k = 1; k <= NS; k++) begin
                int idx;
                idx = (md_ptr + k) % NS;
                if (!found && s_bus.valid_insert[idx]) begin
                    found   = 1'b1;
                    md_gid  = idx;
                    md_ptr  = idx;
                    md_busy = 1'b1;
                    md_hdr  = 1'b0;
                end
            end
        end else begin
            if (e_vins && m_bus.ready_insert) md_hdr = 1'b1;
            if (e_vin && m_bus.ready_in && s_bus.last_in[g]) md_busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        glog.delete(); gcyc.delete(); hcyc.delete(); hlog.delete();
        plog.delete(); lcyc.delete();
        busy_cnt = 0; leak_cnt = 0; early_vin = 0; leak3 = 0;
    endtask

    task automatic do_reset(input bit check_state);
        rst = 1'b1;
        m_bus.ready_in     = 1'b1;
        m_bus.ready_insert = 1'b1;
        tick();
        tick();
        if (check_state) begin
            chk("rst_busy", busy, 1'b0);
            chk("rst_grant_id", grant_id, 2'd0);
            chk("rst_m_valid_in", m_bus.valid_in, 1'b0);
            chk("rst_m_valid_insert", m_bus.valid_insert, 1'b0);
            chk("rst_s_ready_in", s_bus.ready_in, 4'b0000);
            chk("rst_s_ready_insert", s_bus.ready_insert, 4'b0000);
        end
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic push_hdr(input int src, input hdr_t h);
        case (src)
            0:       g_src[0].hq.push_back(h);
            1:       g_src[1].hq.push_back(h);
            2:       g_src[2].hq.push_back(h);
            default: g_src[3].hq.push_back(h);
        endcase
    endtask

    task automatic push_pay(input int src, input logic [31:0] base, input int n);
        pay_t p;
        for (int i = 0; i < n; i++) begin
            p.d = base + 32'(i);
            p.k = 4'hF;
            p.l = (i == n - 1);
            case (src)
                0:       g_src[0].pq.push_back(p);
                1:       g_src[1].pq.push_back(p);
                2:       g_src[2].pq.push_back(p);
                default: g_src[3].pq.push_back(p);
            endcase
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string nm);
        int t = 0;
        while (lcyc.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (lcyc.size() < n) chk({nm, "_timeout"}, lcyc.size(), n);
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_bus.ready_in     = 1'b1;
        m_bus.ready_insert = 1'b1;

        // 1: src2 alone, 3-beat payload
        do_reset(1'b1);
        push_hdr(2, '{d: 32'h0000_1234, k: 4'b0011, c: 2'd1});
        push_pay(2, 32'hA0A1_A2A3, 3);
        wait_frames(1, 50, "t1");
        chk("t1_ngrant", glog.size(), 1);
        chk("t1_grant", glog[0], 2);
        chk("t1_nhdr", hlog.size(), 1);
        chk("t1_hdr", hlog[0], {32'h0000_1234, 4'b0011, 2'd1});
        chk("t1_npay", plog.size(), 3);
        chk("t1_pay0", plog[0], 32'hA0A1_A2A3);
        chk("t1_pay2", plog[2], 32'hA0A1_A2A5);
        chk("t1_busy_cycles", busy_cnt, 3);
        chk("t1_last_after_grant", lcyc[0] - gcyc[0], 2);
        chk("t1_other_ready", leak_cnt, 0);

        // 2: all four request, 1-beat frames, src0 twice
        do_reset(1'b0);
        for (int s = 0; s < NS; s++) begin
            push_hdr(s, '{d: 32'h1000_0000 + 32'(s), k: 4'hF, c: 2'd0});
            push_pay(s, 32'h2000_0000 + 32'(s), 1);
        end
        push_hdr(0, '{d: 32'h1000_0010, k: 4'hF, c: 2'd0});
        push_pay(0, 32'h2000_0010, 1);
        wait_frames(5, 200, "t2");
        chk("t2_ngrant", glog.size(), 5);
        chk("t2_g0", glog[0], 0);
        chk("t2_g1", glog[1], 1);
        chk("t2_g2", glog[2], 2);
        chk("t2_g3", glog[3], 3);
        chk("t2_g4", glog[4], 0);
        chk("t2_hdr_then_last", lcyc[0] - gcyc[0], 1);
        for (int i = 1; i < 5; i++) chk("t2_gap", gcyc[i] - lcyc[i-1], 2);
        chk("t2_pay4", plog[4], 32'h2000_0010);
        chk("t2_other_ready", leak_cnt, 0);

        // 3: src1 frame with toggling payload backpressure
        do_reset(1'b0);
        m_bus.ready_in = 1'b0;
        push_hdr(1, '{d: 32'hCAFE_0001, k: 4'hF, c: 2'd0});
        push_pay(1, 32'h3100_0000, 4);
        for (int t = 0; t < 60 && lcyc.size() < 1; t++) begin
            tick();
            m_bus.ready_in = ~m_bus.ready_in;
        end
        if (lcyc.size() < 1) chk("t3_timeout", lcyc.size(), 1);
        m_bus.ready_in = 1'b1;
        repeat (3) tick();
        chk("t3_npay", plog.size(), 4);
        chk("t3_pay0", plog[0], 32'h3100_0000);
        chk("t3_pay1", plog[1], 32'h3100_0001);
        chk("t3_pay2", plog[2], 32'h3100_0002);
        chk("t3_pay3", plog[3], 32'h3100_0003);
        chk("t3_ngrant", glog.size(), 1);
        chk("t3_grant", glog[0], 1);

        // 4: payload last offered well before the header
        do_reset(1'b0);
        push_pay(1, 32'h4400_0001, 1);
        repeat (5) tick();
        push_hdr(1, '{d: 32'h4400_00AA, k: 4'hF, c: 2'd2});
        wait_frames(1, 40, "t4");
        chk("t4_early_valid", early_vin, 0);
        chk("t4_nhdr", hcyc.size(), 1);
        chk("t4_last_after_hdr", lcyc[0] - hcyc[0], 1);
        chk("t4_pay", plog[0], 32'h4400_0001);
        chk("t4_grant", glog[0], 1);

        // 5: reset mid-frame, then src0 wins first again
        do_reset(1'b0);
        push_hdr(0, '{d: 32'h5000_00AA, k: 4'hF, c: 2'd0});
        push_pay(0, 32'h5000_0000, 4);
        for (int t = 0; t < 30 && plog.size() < 2; t++) tick();
        chk("t5_beats_before_rst", plog.size(), 2);
        rst = 1'b1;
        tick();
        chk("t5_busy", busy, 1'b0);
        chk("t5_m_valid_in", m_bus.valid_in, 1'b0);
        chk("t5_m_valid_insert", m_bus.valid_insert, 1'b0);
        rst = 1'b0;
        clear_logs();
        push_hdr(3, '{d: 32'h5300_00AA, k: 4'hF, c: 2'd0});
        push_pay(3, 32'h5300_0000, 1);
        push_hdr(0, '{d: 32'h5100_00AA, k: 4'hF, c: 2'd0});
        push_pay(0, 32'h5100_0000, 1);
        wait_frames(2, 80, "t5");
        chk("t5_g0", glog[0], 0);
        chk("t5_g1", glog[1], 3);
        chk("t5_pay0", plog[0], 32'h5100_0000);

        // 6: src3 requests during a src0 frame
        do_reset(1'b0);
        push_hdr(0, '{d: 32'h6000_00AA, k: 4'hF, c: 2'd0});
        push_pay(0, 32'h6000_0000, 3);
        tick();
        tick();
        push_hdr(3, '{d: 32'h6300_0033, k: 4'hF, c: 2'd3});
        push_pay(3, 32'h6300_0000, 2);
        wait_frames(2, 80, "t6");
        chk("t6_ngrant", glog.size(), 2);
        chk("t6_g0", glog[0], 0);
        chk("t6_g1", glog[1], 3);
        chk("t6_gap", gcyc[1] - lcyc[0], 2);
        chk("t6_pay3", plog[3], 32'h6300_0000);
        chk("t6_src3_leak", leak3, 0);
        chk("t6_other_ready", leak_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
